// File: rtl/fifo_stream_drain.sv
// Read-side drain engine: pops cmd_len words from a show-ahead FIFO onto a valid/ready stream.
// Latency: a word popped at edge N is on m_valid after edge N; 1 word/cycle sustained.
// Backpressure: m_ready low fills a 2-entry buffer, then pops stall (no m_ready->fifo_rd_en path).
// Optional macro FIFO_DRAIN_TIMEOUT_EN adds a starvation timeout and the timeout_err port.
module fifo_stream_drain #(
  parameter int DATA_WIDTH     = 8,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
`ifdef FIFO_DRAIN_TIMEOUT_EN
  output logic                  done,
  output logic                  timeout_err
`else
  output logic                  done
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [1:0]            occ_q;
  logic [DATA_WIDTH-1:0] head_data, tail_data;
  logic                  head_last, tail_last;
  logic                  done_q, done_d;
  logic                  cmd_fire, out_fire, pop, pop_last, abort;

  assign cmd_ready  = (state_q == IDLE) && !rst;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign m_valid    = (occ_q != 2'd0);
  assign out_fire   = m_valid && m_ready;
  assign m_data     = head_data;
  assign m_last     = head_last;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  // Pop depends only on registered state and fifo_empty so the FIFO never sees m_ready timing.
  assign pop        = (state_q == DRAIN) && !fifo_empty && (remaining_q != '0) && (occ_q != 2'd2);
  assign fifo_rd_en = pop;
  assign pop_last   = (remaining_q == LEN_WIDTH'(1));

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] starve_cnt;
  logic             starve;

  // Starved means nothing left to show downstream and nothing arriving from the FIFO.
  assign starve = (state_q == DRAIN) && fifo_empty && (occ_q == 2'd0);
  assign abort  = starve && (starve_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive starved cycles; latch the error until the next command is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      timeout_err <= 1'b0;
    end else begin
      starve_cnt <= starve ? starve_cnt + CNT_W'(1) : '0;
      if (abort)
        timeout_err <= 1'b1;
      else if (cmd_fire)
        timeout_err <= 1'b0;
    end
  end
`else
  assign abort = 1'b0;
`endif

  // Next-state and done-pulse decode.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len != '0)
            state_d = DRAIN;
          else
            done_d = 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (pop && pop_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_fire && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, done pulse and remaining-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (cmd_fire)
        remaining_q <= cmd_len;
      else if (abort)
        remaining_q <= '0;
      else if (pop)
        remaining_q <= remaining_q - LEN_WIDTH'(1);
    end
  end

  // Two-entry output buffer: head drives the stream, tail only fills while head is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (pop) begin
            head_data <= fifo_data;
            head_last <= pop_last;
            occ_q     <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && out_fire) begin
            head_data <= fifo_data;
            head_last <= pop_last;
          end else if (pop) begin
            tail_data <= fifo_data;
            tail_last <= pop_last;
            occ_q     <= 2'd2;
          end else if (out_fire) begin
            occ_q <= 2'd0;
          end
        end
        2'd2: begin
          if (out_fire) begin
            head_data <= tail_data;
            head_last <= tail_last;
            occ_q     <= 2'd1;
          end
        end
        default: occ_q <= 2'd0;
      endcase
    end
  end

endmodule
